// File: rtl/exec_pipe_rf_if.sv
// Issue and writeback channels of the two-stage execute pipeline.
interface exec_pipe_rf_if #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int IMM_WIDTH     = 8
);
  logic                     issue_valid_i;
  logic                     issue_ready_o;
  logic [2:0]               op_i;
  logic [ADDRESS_WIDTH-1:0] rd_i, ra_i, rb_i;
  logic [IMM_WIDTH-1:0]     imm_i;
  logic                     use_imm_i;
  logic                     wb_valid_o;
  logic                     wb_ready_i;
  logic [ADDRESS_WIDTH-1:0] wb_addr_o;
  logic [WORD_WIDTH-1:0]    wb_data_o;

  modport slave (
    input  issue_valid_i, op_i, rd_i, ra_i, rb_i, imm_i, use_imm_i, wb_ready_i,
    output issue_ready_o, wb_valid_o, wb_addr_o, wb_data_o
  );
  modport master (
    output issue_valid_i, op_i, rd_i, ra_i, rb_i, imm_i, use_imm_i, wb_ready_i,
    input  issue_ready_o, wb_valid_o, wb_addr_o, wb_data_o
  );
endinterface

// File: rtl/exec_pipe_rf.sv
// Two-stage (EX, WB) ALU pipeline with register file, operand forwarding,
// registered flags and a backpressured writeback channel.
module exec_pipe_rf #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int IMM_WIDTH     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  exec_pipe_rf_if.slave            bus,
  output logic                     cf_o,
  output logic                     zf_o,
  output logic                     of_o,
  output logic                     sf_o,
  output logic                     pf_o,
  input  logic [ADDRESS_WIDTH-1:0] dbg_addr_i,
  output logic [WORD_WIDTH-1:0]    dbg_data_o
);
  localparam int W    = WORD_WIDTH;
  localparam int NREG = 1 << ADDRESS_WIDTH;
  localparam int SH   = $clog2(WORD_WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0, OP_ADC = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
                         OP_OR  = 3'd4, OP_XOR = 3'd5, OP_SHL = 3'd6, OP_SAR = 3'd7;

  logic [W-1:0]             rf_q [NREG];
  logic                     ex_vld_q, wb_vld_q;
  logic [2:0]               ex_op_q;
  logic [ADDRESS_WIDTH-1:0] ex_rd_q, wb_addr_q;
  logic [W-1:0]             ex_a_q, ex_b_q, wb_data_q;
  logic                     cf_q, zf_q, of_q, sf_q, pf_q;

  logic         adv, accept;
  logic [W-1:0] opa, opb, imm_ext;
  logic [W-1:0] res_d;
  logic         cf_d, of_d;
  logic [W:0]   sum, diff, shl_ext, sar_ext;
  logic [SH-1:0] sh;

  assign adv    = !(wb_vld_q && !bus.wb_ready_i);
  assign accept = bus.issue_valid_i && adv;
  assign imm_ext = {{(W-IMM_WIDTH){bus.imm_i[IMM_WIDTH-1]}}, bus.imm_i};

  // Youngest producer wins; register 0 always reads as the RF zero.
  function automatic logic [W-1:0] fetch(input logic [ADDRESS_WIDTH-1:0] s);
    if (s != '0 && ex_vld_q && ex_rd_q == s)        return res_d;
    else if (s != '0 && wb_vld_q && wb_addr_q == s) return wb_data_q;
    else                                            return rf_q[s];
  endfunction

  always_comb begin
    opa = fetch(bus.ra_i);
    opb = bus.use_imm_i ? imm_ext : fetch(bus.rb_i);
  end

  assign sh      = ex_b_q[SH-1:0];
  assign sum     = {1'b0, ex_a_q} + {1'b0, ex_b_q} + {{W{1'b0}}, (ex_op_q == OP_ADC) & cf_q};
  assign diff    = {1'b0, ex_a_q} - {1'b0, ex_b_q};
  // One extra bit on the shifted-out side captures the last bit lost.
  assign shl_ext = {1'b0, ex_a_q} << sh;
  assign sar_ext = $signed({ex_a_q, 1'b0}) >>> sh;

  always_comb begin
    res_d = '0;
    cf_d  = 1'b0;
    of_d  = 1'b0;
    case (ex_op_q)
      OP_ADD, OP_ADC: begin
        res_d = sum[W-1:0];
        cf_d  = sum[W];
        of_d  = (ex_a_q[W-1] == ex_b_q[W-1]) && (sum[W-1] != ex_a_q[W-1]);
      end
      OP_SUB: begin
        res_d = diff[W-1:0];
        cf_d  = diff[W];
        of_d  = (ex_a_q[W-1] != ex_b_q[W-1]) && (diff[W-1] != ex_a_q[W-1]);
      end
      OP_AND: res_d = ex_a_q & ex_b_q;
      OP_OR:  res_d = ex_a_q | ex_b_q;
      OP_XOR: res_d = ex_a_q ^ ex_b_q;
      OP_SHL: begin
        res_d = shl_ext[W-1:0];
        cf_d  = shl_ext[W];
      end
      default: begin
        res_d = sar_ext[W:1];
        cf_d  = sar_ext[0];
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      ex_vld_q  <= 1'b0;
      ex_op_q   <= '0;
      ex_rd_q   <= '0;
      ex_a_q    <= '0;
      ex_b_q    <= '0;
      wb_vld_q  <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      {cf_q, zf_q, of_q, sf_q, pf_q} <= '0;
    end else begin
      if (adv) begin
        ex_vld_q <= accept;
        if (accept) begin
          ex_op_q <= bus.op_i;
          ex_rd_q <= bus.rd_i;
          ex_a_q  <= opa;
          ex_b_q  <= opb;
        end
        wb_vld_q <= ex_vld_q;
        if (ex_vld_q) begin
          wb_addr_q <= ex_rd_q;
          wb_data_q <= res_d;
          cf_q <= cf_d;
          of_q <= of_d;
          zf_q <= (res_d == '0);
          sf_q <= res_d[W-1];
          pf_q <= ~^res_d[7:0];
        end
      end
      if (wb_vld_q && bus.wb_ready_i && wb_addr_q != '0)
        rf_q[wb_addr_q] <= wb_data_q;
    end
  end

  assign bus.issue_ready_o = adv;
  assign bus.wb_valid_o    = wb_vld_q;
  assign bus.wb_addr_o     = wb_addr_q;
  assign bus.wb_data_o     = wb_data_q;
  assign {cf_o, zf_o, of_o, sf_o, pf_o} = {cf_q, zf_q, of_q, sf_q, pf_q};
  assign dbg_data_o = rf_q[dbg_addr_i];
endmodule

// File: tb/tb_exec_pipe_rf.sv
// Directed bench for exec_pipe_rf: hand-computed writeback values and flags.
module tb_exec_pipe_rf;
  logic        clk = 1'b0;
  logic        rst;
  logic        cf, zf, of, sf, pf;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  int          total = 0, bad = 0, wb_cnt = 0, cnt0;

  exec_pipe_rf_if #(.WORD_WIDTH(32), .ADDRESS_WIDTH(5), .IMM_WIDTH(8)) bus ();

  exec_pipe_rf #(.WORD_WIDTH(32), .ADDRESS_WIDTH(5), .IMM_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave),
    .cf_o(cf), .zf_o(zf), .of_o(of), .sf_o(sf), .pf_o(pf),
    .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && bus.wb_valid_o && bus.wb_ready_i) wb_cnt <= wb_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] rd, ra, rb,
                       input logic [7:0] imm, input logic ui);
    bus.issue_valid_i = 1'b1;
    bus.op_i = op; bus.rd_i = rd; bus.ra_i = ra; bus.rb_i = rb;
    bus.imm_i = imm; bus.use_imm_i = ui;
    @(posedge clk); #1;
    bus.issue_valid_i = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic wb(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_vld"}, bus.wb_valid_o, 1'b1);
    chk({tag, "_addr"}, bus.wb_addr_o, a);
    chk({tag, "_data"}, bus.wb_data_o, d);
  endtask

  task automatic flg(input string tag, input logic [4:0] exp);
    chk({tag, "_flags"}, {cf, zf, of, sf, pf}, exp);
  endtask

  task automatic dbg(input string tag, input logic [4:0] a, input logic [31:0] d);
    dbg_addr = a; #1;
    chk(tag, dbg_data, d);
  endtask

  localparam logic [2:0] ADD = 0, ADC = 1, SUB = 2, SHL = 6, SAR = 7;

  initial begin
    rst = 1'b1; dbg_addr = '0; bus.wb_ready_i = 1'b1;
    bus.issue_valid_i = 1'b0; bus.op_i = '0; bus.rd_i = '0; bus.ra_i = '0;
    bus.rb_i = '0; bus.imm_i = '0; bus.use_imm_i = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    chk("rst_vld", bus.wb_valid_o, 1'b0);
    chk("rst_rdy", bus.issue_ready_o, 1'b1);
    flg("rst", 5'b00000);

    // ADD r1 = r0 + 5 ; flags order c z o s p
    issue(ADD, 1, 0, 0, 8'd5, 1);
    chk("add_ex_vld", bus.wb_valid_o, 1'b0);
    idle();
    wb("add", 1, 5); flg("add", 5'b00001);
    idle();
    chk("add_bubble", bus.wb_valid_o, 1'b0);
    dbg("add_rf", 1, 5);

    // forwarding chain 127, 254, 381
    issue(ADD, 1, 0, 0, 8'h7F, 1);
    issue(ADD, 2, 1, 1, 8'h00, 0);
    wb("fw1", 1, 127);
    issue(ADD, 3, 1, 2, 8'h00, 0);
    wb("fw2", 2, 254);
    idle();
    wb("fw3", 3, 381);
    idle();
    dbg("fw_r2", 2, 254);
    dbg("fw_r3", 3, 381);

    // backpressure
    cnt0 = wb_cnt;
    issue(ADD, 5, 0, 0, 8'd10, 1);
    bus.wb_ready_i = 1'b0;
    issue(ADD, 6, 5, 0, 8'd1, 1);
    for (int i = 0; i < 3; i++) begin
      wb("bp_hold", 5, 10);
      chk("bp_rdy", bus.issue_ready_o, 1'b0);
      dbg("bp_dbg", 5, 0);
      if (i < 2) idle();
    end
    bus.wb_ready_i = 1'b1;
    idle();
    wb("bp_i2", 6, 11);
    dbg("bp_r5", 5, 10);
    idle();
    chk("bp_drain", bus.wb_valid_o, 1'b0);
    dbg("bp_r6", 6, 11);
    chk("bp_once", wb_cnt - cnt0, 2);

    // flags: SUB, ADD wrap, ADC carry-in
    issue(SUB, 1, 0, 0, 8'd1, 1);
    issue(ADD, 2, 1, 0, 8'd1, 1);
    wb("sub", 1, 32'hFFFF_FFFF); flg("sub", 5'b10011);
    issue(ADC, 3, 0, 0, 8'd0, 1);
    wb("addz", 2, 0); flg("addz", 5'b11001);
    idle();
    wb("adc", 3, 1); flg("adc", 5'b00000);

    // shifts with EX and WB forwarding
    issue(ADD, 9, 0, 0, 8'h81, 1);
    issue(SAR, 10, 9, 0, 8'd1, 1);
    wb("sext", 9, 32'hFFFF_FF81); flg("sext", 5'b00011);
    issue(SHL, 11, 9, 0, 8'd25, 1);
    wb("sar", 10, 32'hFFFF_FFC0); flg("sar", 5'b10011);
    idle();
    wb("shl", 11, 32'h0200_0000); flg("shl", 5'b10001);

    // signed overflow on SUB
    issue(ADD, 14, 0, 0, 8'd1, 1);
    issue(SHL, 13, 14, 0, 8'd31, 1);
    wb("one", 14, 1);
    issue(SUB, 15, 13, 0, 8'd1, 1);
    wb("shl31", 13, 32'h8000_0000); flg("shl31", 5'b00011);
    idle();
    wb("ovf", 15, 32'h7FFF_FFFF); flg("ovf", 5'b00101);

    // register 0
    issue(ADD, 0, 0, 0, 8'd9, 1);
    issue(ADD, 4, 0, 0, 8'd0, 0);
    wb("r0w", 0, 9);
    idle();
    wb("r0r", 4, 0);
    idle();
    dbg("r0_rf", 0, 0);
    dbg("r4_rf", 4, 0);

    // reset mid-flight
    issue(ADD, 20, 0, 0, 8'd3, 1);
    issue(ADD, 21, 0, 0, 8'd4, 1);
    wb("mf_pre", 20, 3);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("mf_vld", bus.wb_valid_o, 1'b0);
    chk("mf_data", bus.wb_data_o, 0);
    chk("mf_rdy", bus.issue_ready_o, 1'b1);
    flg("mf", 5'b00000);
    dbg("mf_r20", 20, 0);
    dbg("mf_r1", 1, 0);
    idle();
    chk("mf_vld2", bus.wb_valid_o, 1'b0);
    dbg("mf_r21", 21, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exec_pipe_rf.md
EXEC_PIPE_RF -- requirements
Module: exec_pipe_rf

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, datapath width; must be a power of two, at least 8.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, register address width; 2^ADDRESS_WIDTH registers.
REQ-003 SHALL have parameter IMM_WIDTH, default 8, immediate width; less than WORD_WIDTH.
REQ-004 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port issue_valid_i  in  1  instruction offered.
REQ-007 SHALL have port issue_ready_o  out  1  instruction accepted when valid and ready are both high.
REQ-008 SHALL have port op_i  in  3  opcode: 0 ADD, 1 ADC, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SAR.
REQ-009 SHALL have ports rd_i, ra_i, rb_i  in  ADDRESS_WIDTH each  destination and sources.
REQ-010 SHALL have ports imm_i  in  IMM_WIDTH  immediate; use_imm_i  in  1  operand B = sign-extended imm_i instead of rb.
REQ-011 SHALL have ports wb_valid_o  out  1; wb_ready_i  in  1; wb_addr_o  out  ADDRESS_WIDTH; wb_data_o  out  WORD_WIDTH: the writeback channel.
REQ-012 SHALL have ports cf_o, zf_o, of_o, sf_o, pf_o  out  1 each  registered flags.
REQ-013 SHALL have ports dbg_addr_i  in  ADDRESS_WIDTH; dbg_data_o  out  WORD_WIDTH: combinational read of RF contents, no forwarding.

Function
REQ-014 SHALL be a two-stage pipeline: an instruction accepted at edge T occupies EX during cycle T+1 and WB during cycle T+2, with wb_valid_o=1 in cycle T+2 when not stalled.
REQ-015 SHALL define advance = !(wb_valid_o && !wb_ready_i); issue_ready_o = advance.
REQ-016 SHALL freeze the EX and WB registers, flags and outputs while advance=0; wb_addr_o and wb_data_o stay stable while wb_valid_o=1 and wb_ready_i=0.
REQ-017 SHALL write wb_data_o into the RF at wb_addr_o on the edge where wb_valid_o && wb_ready_i.
REQ-018 SHALL hard-wire register 0 to zero: writes are discarded, but wb_data_o still reports the computed value.
REQ-019 SHALL read operands during the issue cycle with forwarding priority: EX-stage result, then WB register, then RF.
REQ-020 SHALL never forward for source address 0.
REQ-021 SHALL compute in EX with all arithmetic modulo 2^WORD_WIDTH.
REQ-022 SHALL set ADC result = A+B+cf_o.
REQ-023 SHALL set SUB result = A-B.
REQ-024 SHALL take the shift amount for SHL and SAR as B[log2(WORD_WIDTH)-1:0]; SAR is arithmetic.
REQ-025 SHALL set cf: ADD/ADC carry out; SUB =1 when A<B unsigned; SHL/SAR last bit shifted out, 0 when shift is 0; logic ops 0.
REQ-026 SHALL set of to signed overflow for ADD/ADC/SUB and 0 otherwise; zf = result==0; sf = result MSB; pf = 1 when result[7:0] has an even number of ones.
REQ-027 SHALL update the flags register on the edge the EX instruction moves to WB, so that ADC uses the flags of the most recent executed instruction; bubbles leave flags unchanged.
REQ-028 SHALL insert a bubble (wb_valid_o=0) in cycles following cycles with no accepted issue.

Reset
REQ-029 SHALL, with rst_i high at an edge, clear all RF registers, EX and WB valid bits, all flags, wb_valid_o, wb_addr_o and wb_data_o to 0, overriding any simultaneous issue or handshake.
REQ-030 SHALL drive issue_ready_o=1 in the cycle after reset.
REQ-031 SHALL discard in-flight instructions on reset with no RF write.

Verification
REQ-032 SHALL cover: reset; ADD r1=r0+imm 5 accepted at T -> wb_valid_o=1 at T+2, wb_addr_o=1, wb_data_o=5, all flags 0 except pf=1.
REQ-033 SHALL cover back-to-back forwarding: r1=r0+imm 0x7F; r2=r1+r1; r3=r1+r2 on consecutive cycles, wb_ready_i=1 -> wb_data_o sequence 127, 254, 381.
REQ-034 SHALL cover backpressure: wb_ready_i low 3 cycles with wb_valid_o=1 -> wb outputs held, issue_ready_o=0, dbg_data_o keeps old value; after release, each instruction is written exactly once, in order.
REQ-035 SHALL cover flags: SUB r1=r0-imm 1 -> 0xFFFFFFFF with cf=1, sf=1; ADD r2=r1+imm 1 -> 0 with cf=1, zf=1, of=0; ADC r3=r0+imm 0 -> 1.
REQ-036 SHALL cover register 0: ADD r0=r0+imm 9 -> wb_data_o=9; an immediately following ADD r4=r0+r0 -> 0; dbg read of r0 -> 0.
REQ-037 SHALL cover reset mid-flight: two instructions in EX/WB, rst_i high one cycle -> next cycle wb_valid_o=0, flags 0, no RF change beyond clearing.
